// File: rtl/uart_pkg.sv
// Shared definitions for the D-bus UART transmitter: register word indices,
// STATUS/CTRL bit positions and the transmit FSM state encoding.
package uart_pkg;

    // Register word index (addr[3:2]); byte offsets 0x0, 0x4, 0x8, 0xC
    localparam logic [1:0] REG_TXDATA  = 2'd0;
    localparam logic [1:0] REG_STATUS  = 2'd1;
    localparam logic [1:0] REG_BAUDDIV = 2'd2;
    localparam logic [1:0] REG_CTRL    = 2'd3;

    // STATUS bit positions; the FIFO level field starts at ST_LEVEL
    localparam int ST_FULL  = 0;
    localparam int ST_EMPTY = 1;
    localparam int ST_BUSY  = 2;
    localparam int ST_OVF   = 3;
    localparam int ST_LEVEL = 8;

    // CTRL bit positions
    localparam int CTRL_EN     = 0;
    localparam int CTRL_IRQ_EN = 1;
    localparam int CTRL_ODD    = 2;

    // Transmit FSM states; TX_PARITY is only visited in the parity build
    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_START  = 3'd1,
        TX_DATA   = 3'd2,
        TX_PARITY = 3'd3,
        TX_STOP   = 3'd4
    } tx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with a combinational head read. A push into a full FIFO
// is accepted when a pop happens in the same cycle; otherwise it is dropped.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = 1;
    localparam logic [AW:0]   CNT_ONE  = 1;
    localparam logic [AW:0]   FULL_CNT = DEPTH[AW:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign level   = count;
    assign rdata   = mem[rd_ptr];
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);

    // Storage array: written on an accepted push, no reset needed
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers and occupancy count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop_ok)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_dbus.sv
// Memory-mapped 8N1 UART transmitter behind the D-bus with a TX FIFO.
// Define UART_TX_PARITY_EN to add a parity bit (CTRL[2] selects odd parity).
//
// Bus handshake: a request sampled with req=1 at clock edge N takes its
// register side effects at edge N and returns ack=1 for exactly one cycle
// after edge N, with rdata valid only while ack=1 (0 otherwise). A new req
// may be presented in the ack cycle; accesses can be issued back to back.
module uart_tx_dbus
    import uart_pkg::*;
#(
    parameter int               FIFO_DEPTH = 16,
    parameter int               DIV_W      = 16,
    parameter logic [DIV_W-1:0] DIV_RESET  = 16'd433
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic        we,
    input  logic [3:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ack,
    output logic        tx,
    output logic        irq
);

    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [DIV_W-1:0] DIV_ONE = 1;

    tx_state_e        state;
    tx_state_e        state_nxt;
    logic [DIV_W-1:0] baud_div;
    logic [DIV_W-1:0] div_lat;
    logic [DIV_W-1:0] baud_cnt;
    logic [7:0]       shift_q;
    logic [2:0]       bit_idx;
    logic             ctrl_en;
    logic             ctrl_irq_en;
    logic             ctrl_odd;
    logic             ovf;
    logic             busy;
    logic             pop;
    logic             push;
    logic             full;
    logic             empty;
    logic [LVL_W-1:0] level;
    logic [7:0]       fifo_rdata;
    logic [31:0]      rd_mux;
    logic             wr_status;
    logic             wr_baud;
    logic             wr_ctrl;
    logic             bit_end;
    logic             can_pop;
    logic             unused_bits;

    assign push        = req & we & (addr[3:2] == REG_TXDATA);
    assign wr_status   = req & we & (addr[3:2] == REG_STATUS);
    assign wr_baud     = req & we & (addr[3:2] == REG_BAUDDIV);
    assign wr_ctrl     = req & we & (addr[3:2] == REG_CTRL);
    assign bit_end     = (baud_cnt == '0);
    assign can_pop     = ctrl_en & ~empty;
    assign unused_bits = ^{wdata, addr[1:0]};

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata (wdata[7:0]),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (full),
        .empty (empty),
        .level (level)
    );

    // Configuration registers and the sticky overflow flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            baud_div    <= DIV_RESET;
            ctrl_en     <= 1'b0;
            ctrl_irq_en <= 1'b0;
            ovf         <= 1'b0;
        end else begin
            if (wr_baud) baud_div <= wdata[DIV_W-1:0];
            if (wr_ctrl) begin
                ctrl_en     <= wdata[CTRL_EN];
                ctrl_irq_en <= wdata[CTRL_IRQ_EN];
            end
            if (push & full & ~pop)            ovf <= 1'b1;
            else if (wr_status & wdata[ST_OVF]) ovf <= 1'b0;
        end
    end

`ifdef UART_TX_PARITY_EN
    logic par_q;

    // Parity polarity select, only stored when parity is built in
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       ctrl_odd <= 1'b0;
        else if (wr_ctrl) ctrl_odd <= wdata[CTRL_ODD];
    end
`else
    assign ctrl_odd = 1'b0;
`endif

    // Read mux for the register map
    always_comb begin
        rd_mux = '0;
        case (addr[3:2])
            REG_STATUS: begin
                rd_mux[ST_FULL]            = full;
                rd_mux[ST_EMPTY]           = empty;
                rd_mux[ST_BUSY]            = busy;
                rd_mux[ST_OVF]             = ovf;
                rd_mux[ST_LEVEL +: LVL_W]  = level;
            end
            REG_BAUDDIV: rd_mux[DIV_W-1:0] = baud_div;
            REG_CTRL: begin
                rd_mux[CTRL_EN]     = ctrl_en;
                rd_mux[CTRL_IRQ_EN] = ctrl_irq_en;
                rd_mux[CTRL_ODD]    = ctrl_odd;
            end
            default: rd_mux = '0;
        endcase
    end

    // Bus response: one-cycle ack, read data only during ack
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack   <= 1'b0;
            rdata <= '0;
        end else begin
            ack   <= req;
            rdata <= (req & ~we) ? rd_mux : '0;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= TX_IDLE;
        else        state <= state_nxt;
    end

    // FSM next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            TX_IDLE:  if (can_pop) state_nxt = TX_START;
            TX_START: if (bit_end) state_nxt = TX_DATA;
            TX_DATA: begin
                if (bit_end && bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                    state_nxt = TX_PARITY;
`else
                    state_nxt = TX_STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            TX_PARITY: if (bit_end) state_nxt = TX_STOP;
`endif
            TX_STOP:  if (bit_end) state_nxt = can_pop ? TX_START : TX_IDLE;
            default:  state_nxt = TX_IDLE;
        endcase
    end

    // FSM outputs: line level, busy, and FIFO pop at frame start
    always_comb begin
        busy = (state != TX_IDLE);
        pop  = can_pop & ((state == TX_IDLE) | ((state == TX_STOP) & bit_end));
        case (state)
            TX_START:  tx = 1'b0;
            TX_DATA:   tx = shift_q[0];
`ifdef UART_TX_PARITY_EN
            TX_PARITY: tx = par_q;
`endif
            default:   tx = 1'b1;
        endcase
    end

    // Frame datapath: the divisor is latched at frame start so BAUDDIV writes
    // made mid-frame only affect the next frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q  <= '0;
            bit_idx  <= '0;
            baud_cnt <= '0;
            div_lat  <= '0;
        end else if (pop) begin
            shift_q  <= fifo_rdata;
            bit_idx  <= '0;
            baud_cnt <= baud_div;
            div_lat  <= baud_div;
        end else if (state != TX_IDLE) begin
            if (bit_end) begin
                baud_cnt <= div_lat;
                if (state == TX_DATA) begin
                    shift_q <= shift_q >> 1;
                    bit_idx <= bit_idx + 3'd1;
                end
            end else begin
                baud_cnt <= baud_cnt - DIV_ONE;
            end
        end
    end

`ifdef UART_TX_PARITY_EN
    // Parity bit computed from the whole byte when it is loaded
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   par_q <= 1'b0;
        else if (pop) par_q <= (^fifo_rdata) ^ ctrl_odd;
    end
`endif

    // Level interrupt, registered one cycle behind its inputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) irq <= 1'b0;
        else        irq <= ctrl_irq_en & empty & ~busy;
    end

endmodule

// File: tb/tb_uart_tx_dbus.sv
// Directed testbench for uart_tx_dbus; honours UART_TX_PARITY_EN.
module tb_uart_tx_dbus;

`ifdef UART_TX_PARITY_EN
    localparam int          NB      = 11;
    localparam logic [31:0] CTRL_RB = 32'h7;
`else
    localparam int          NB      = 10;
    localparam logic [31:0] CTRL_RB = 32'h3;
`endif

    logic        clk;
    logic        rst_n;
    logic        req;
    logic        we;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ack;
    logic        tx;
    logic        irq;

    int checks = 0;
    int errors = 0;

    uart_tx_dbus dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .we    (we),
        .addr  (addr),
        .wdata (wdata),
        .rdata (rdata),
        .ack   (ack),
        .tx    (tx),
        .irq   (irq)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        req = 1'b1; we = 1'b1; addr = a; wdata = d;
        @(negedge clk);
        chk("ack_wr", {31'b0, ack}, 32'h1);
        req = 1'b0; we = 1'b0; wdata = '0;
    endtask

    task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
        @(negedge clk);
        req = 1'b1; we = 1'b0; addr = a;
        @(negedge clk);
        chk("ack_rd", {31'b0, ack}, 32'h1);
        d = rdata;
        req = 1'b0;
    endtask

    task automatic read_chk(input string tag, input logic [3:0] a, input logic [31:0] exp);
        logic [31:0] d;
        bus_read(a, d);
        chk(tag, d, exp);
    endtask

    // Checks one frame cycle by cycle, starting at the first START cycle;
    // max_wait bounds how many extra cycles the start may be delayed
    task automatic check_frame(input logic [7:0] b, input int div, input logic odd,
                               input int max_wait);
        logic [10:0] fr;
        int w;
        fr = '1;
        fr[0] = 1'b0;
        fr[8:1] = b;
`ifdef UART_TX_PARITY_EN
        fr[9] = (^b) ^ odd;
`endif
        @(negedge clk);
        w = 0;
        while (tx !== 1'b0 && w < max_wait) begin
            @(negedge clk);
            w++;
        end
        chk("frame_start", {31'b0, tx}, 32'h0);
        for (int k = 1; k < NB * (div + 1); k++) begin
            @(negedge clk);
            chk($sformatf("frame_%02h_c%0d", b, k), {31'b0, tx}, {31'b0, fr[k / (div + 1)]});
        end
    endtask

    initial begin
        int low;
        rst_n = 1'b0; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
        repeat (3) @(negedge clk);
        chk("tx_in_reset", {31'b0, tx}, 32'h1);
        rst_n = 1'b1;

        // 1. Reset values
        @(negedge clk);
        chk("rst_tx", {31'b0, tx}, 32'h1);
        chk("rst_ack", {31'b0, ack}, 32'h0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_irq", {31'b0, irq}, 32'h0);
        read_chk("rst_status", 4'h4, 32'h0000_0002);
        @(negedge clk);
        chk("rdata_idle", rdata, 32'h0);
        read_chk("rst_bauddiv", 4'h8, 32'd433);
        read_chk("rst_ctrl", 4'hC, 32'h0);
        read_chk("txdata_rd", 4'h0, 32'h0);

        // 2. Single frame 0xA5 at DIV=3; upper BAUDDIV bits read 0
        bus_write(4'h8, 32'hFFFF_0003);
        read_chk("bauddiv_rb", 4'h8, 32'h3);
        bus_write(4'hC, 32'h1);
        bus_write(4'h0, 32'h0000_00A5);
        check_frame(8'hA5, 3, 1'b0, 0);
        chk("busy_last", {31'b0, dut.busy}, 32'h1);
        @(negedge clk);
        chk("busy_drop40", {31'b0, dut.busy}, 32'h0);
        repeat (2) @(negedge clk);
        chk("irq_disabled", {31'b0, irq}, 32'h0);

        // 3. Overflow, OVF clear, 16 back-to-back frames
        bus_write(4'hC, 32'h0);
        for (int i = 0; i < 17; i++) bus_write(4'h0, 32'h10 + 32'(i));
        read_chk("status_full_ovf", 4'h4, 32'h0000_1009);
        bus_write(4'h4, 32'h8);
        read_chk("status_ovf_clr", 4'h4, 32'h0000_1001);
        bus_write(4'hC, 32'h1);
        for (int i = 0; i < 16; i++) check_frame(8'h10 + 8'(i), 3, 1'b0, 0);
        read_chk("status_drained", 4'h4, 32'h0000_0002);

        // 4. Mid-frame BAUDDIV/CTRL writes
        bus_write(4'hC, 32'h0);
        bus_write(4'h0, 32'h3C);
        bus_write(4'h0, 32'hC3);
        bus_write(4'hC, 32'h1);
        fork
            check_frame(8'h3C, 3, 1'b0, 0);
            begin
                repeat (20) @(negedge clk);
                bus_write(4'h8, 32'h7);
                bus_write(4'hC, 32'h0);
            end
        join
        low = 0;
        repeat (40) begin
            @(negedge clk);
            if (tx !== 1'b1) low++;
        end
        chk("queued_idle_low", 32'(low), 32'h0);
        read_chk("status_queued", 4'h4, 32'h0000_0100);
        bus_write(4'hC, 32'h1);
        check_frame(8'hC3, 7, 1'b0, 0);

        // 5. Interrupt behaviour
        bus_write(4'hC, 32'h3);
        @(negedge clk);
        chk("irq_on_idle", {31'b0, irq}, 32'h1);
        bus_write(4'h0, 32'h5A);
        check_frame(8'h5A, 7, 1'b0, 0);
        chk("irq_in_frame", {31'b0, irq}, 32'h0);
        @(negedge clk);
        chk("busy_fell", {31'b0, dut.busy}, 32'h0);
        chk("irq_lag", {31'b0, irq}, 32'h0);
        @(negedge clk);
        chk("irq_rise", {31'b0, irq}, 32'h1);
        bus_write(4'h0, 32'h81);
        @(negedge clk);
        chk("irq_fall", {31'b0, irq}, 32'h0);
        repeat (NB * 8 + 4) @(negedge clk);
        chk("irq_after_81", {31'b0, irq}, 32'h1);

        // BAUDDIV=0: one clock per bit
        bus_write(4'h8, 32'h0);
        bus_write(4'h0, 32'h96);
        check_frame(8'h96, 0, 1'b0, 0);

        // CTRL readback (odd bit only stored in the parity build)
        bus_write(4'h8, 32'h3);
        bus_write(4'hC, 32'h7);
        read_chk("ctrl_rb", 4'hC, CTRL_RB);

`ifdef UART_TX_PARITY_EN
        // 6. Parity polarity
        bus_write(4'hC, 32'h3);
        bus_write(4'h0, 32'h07);
        check_frame(8'h07, 3, 1'b0, 0);
        bus_write(4'hC, 32'h7);
        bus_write(4'h0, 32'h07);
        check_frame(8'h07, 3, 1'b1, 0);
`endif

        // Reset asserted mid-frame
        bus_write(4'h0, 32'h00);
        repeat (10) @(negedge clk);
        chk("pre_reset_low", {31'b0, tx}, 32'h0);
        rst_n = 1'b0;
        #1;
        chk("reset_tx_now", {31'b0, tx}, 32'h1);
        chk("reset_irq", {31'b0, irq}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        read_chk("post_rst_status", 4'h4, 32'h0000_0002);
        read_chk("post_rst_baud", 4'h8, 32'd433);
        read_chk("post_rst_ctrl", 4'hC, 32'h0);
        repeat (5) @(negedge clk);
        chk("post_rst_tx", {31'b0, tx}, 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
